// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
// - LD_* : 3-bit load-type encodings carried from decode to WB.
// - wb_state_e : writeback FSM state (IDLE = empty or non-load, WAIT = load awaiting data).
package wb_pkg;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;
  localparam logic [2:0] LD_D  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks the addressed byte/half/word out of a naturally
// aligned data-RAM word and sign- or zero-extends it to the register width.
// Ports:
//   ld_op_i    load type (wb_pkg LD_*)
//   offset_i   byte offset within the data word
//   rdata_i    raw data-RAM word
//   data_o     aligned, extended result
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SUBWORD = 1,
  localparam int OFF_W  = (DATA_W == 64) ? 3 : 2
) (
  input  logic [2:0]        ld_op_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o
);

  logic [OFF_W+2:0]  shamt;
  logic [DATA_W-1:0] shifted;

  // Byte offset -> bit shift so the addressed element lands in the low bits.
  assign shamt   = {offset_i, 3'b000};
  assign shifted = rdata_i >> shamt;

  always_comb begin
    data_o = rdata_i;
    if (SUBWORD != 0) begin
      case (ld_op_i)
        LD_B:    data_o = DATA_W'($signed(shifted[7:0]));
        LD_BU:   data_o = DATA_W'(shifted[7:0]);
        LD_H:    data_o = DATA_W'($signed(shifted[15:0]));
        LD_HU:   data_o = DATA_W'(shifted[15:0]);
        // On a 64-bit datapath a word load is sign-extended; at 32 bits it is the raw word.
        LD_W:    data_o = DATA_W'($signed(shifted[31:0]));
        default: data_o = rdata_i;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage_ld.sv
// Registered writeback stage between MEM and the register file.
// Holds one instruction behind a valid/ready handshake; loads wait in WAIT for the
// data-RAM response, which is aligned and written combinationally in the cycle it arrives.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        handshake from MEM
//   in_pc, in_alu_result,
//   in_res_from_mem, in_ld_op,
//   in_gr_we, in_dest        instruction payload
//   mem_rvalid, mem_rdata    load response
//   rf_we/rf_waddr/rf_wdata  register-file write port
//   fwd_valid/fwd_dest/
//   fwd_data_ok              hazard/forwarding status of the held instruction
//   debug_wb_*               retirement trace
module wb_stage_ld
  import wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int PC_W    = 32,
  parameter int SUBWORD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              in_res_from_mem,
  input  logic [2:0]        in_ld_op,
  input  logic              in_gr_we,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_dest,
  output logic              fwd_data_ok,
  output logic [PC_W-1:0]   debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [REG_AW-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);

  localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

  wb_state_e         state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [2:0]        ld_op_q, ld_op_d;
  logic              gr_we_q, gr_we_d;
  logic [REG_AW-1:0] dest_q, dest_d;

  logic              data_ok;
  logic              retire;
  logic              accept;
  logic [DATA_W-1:0] ld_data;

  // Only a held load in WAIT depends on mem_rvalid; a response seen in IDLE is ignored.
  assign data_ok  = (state_q == IDLE) | mem_rvalid;
  assign retire   = wb_valid_q & data_ok;
  assign in_ready = ~wb_valid_q | retire;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    wb_valid_d = wb_valid_q;
    pc_d       = pc_q;
    alu_d      = alu_q;
    ld_op_d    = ld_op_q;
    gr_we_d    = gr_we_q;
    dest_d     = dest_q;
    if (accept) begin
      // Accept overrides retire: the slot is refilled in the same cycle it drains.
      state_d    = in_res_from_mem ? WAIT : IDLE;
      wb_valid_d = 1'b1;
      pc_d       = in_pc;
      alu_d      = in_alu_result;
      ld_op_d    = in_ld_op;
      gr_we_d    = in_gr_we;
      dest_d     = in_dest;
    end else if (retire) begin
      state_d    = IDLE;
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      pc_q       <= '0;
      alu_q      <= '0;
      ld_op_q    <= '0;
      gr_we_q    <= 1'b0;
      dest_q     <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      pc_q       <= pc_d;
      alu_q      <= alu_d;
      ld_op_q    <= ld_op_d;
      gr_we_q    <= gr_we_d;
      dest_q     <= dest_d;
    end
  end

  wb_load_align #(
    .DATA_W  (DATA_W),
    .SUBWORD (SUBWORD)
  ) u_align (
    .ld_op_i  (ld_op_q),
    .offset_i (alu_q[OFF_W-1:0]),
    .rdata_i  (mem_rdata),
    .data_o   (ld_data)
  );

  assign rf_we    = retire & gr_we_q;
  assign rf_waddr = dest_q;
  assign rf_wdata = (state_q == WAIT) ? ld_data : alu_q;

  assign fwd_valid   = wb_valid_q & gr_we_q & (dest_q != '0);
  assign fwd_dest    = dest_q;
  assign fwd_data_ok = wb_valid_q & data_ok;

  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage_ld.sv
module tb_wb_stage_ld;
  import wb_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int PC_W   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_alu_result;
  logic              in_res_from_mem;
  logic [2:0]        in_ld_op;
  logic              in_gr_we;
  logic [REG_AW-1:0] in_dest;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // Instance a: SUBWORD=1
  logic              in_ready_a, rf_we_a, fwd_valid_a, fwd_data_ok_a;
  logic [REG_AW-1:0] rf_waddr_a, fwd_dest_a, dbg_wnum_a;
  logic [DATA_W-1:0] rf_wdata_a, dbg_wdata_a;
  logic [PC_W-1:0]   dbg_pc_a;
  logic [3:0]        dbg_we_a;
  // Instance b: SUBWORD=0
  logic              in_ready_b, rf_we_b, fwd_valid_b, fwd_data_ok_b;
  logic [REG_AW-1:0] rf_waddr_b, fwd_dest_b, dbg_wnum_b;
  logic [DATA_W-1:0] rf_wdata_b, dbg_wdata_b;
  logic [PC_W-1:0]   dbg_pc_b;
  logic [3:0]        dbg_we_b;

  always #5 clk = ~clk;

  wb_stage_ld #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W), .SUBWORD(1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_pc(in_pc),
    .in_alu_result(in_alu_result), .in_res_from_mem(in_res_from_mem), .in_ld_op(in_ld_op),
    .in_gr_we(in_gr_we), .in_dest(in_dest), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we_a), .rf_waddr(rf_waddr_a), .rf_wdata(rf_wdata_a), .fwd_valid(fwd_valid_a),
    .fwd_dest(fwd_dest_a), .fwd_data_ok(fwd_data_ok_a), .debug_wb_pc(dbg_pc_a),
    .debug_wb_rf_we(dbg_we_a), .debug_wb_rf_wnum(dbg_wnum_a), .debug_wb_rf_wdata(dbg_wdata_a)
  );

  wb_stage_ld #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W), .SUBWORD(0)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_pc(in_pc),
    .in_alu_result(in_alu_result), .in_res_from_mem(in_res_from_mem), .in_ld_op(in_ld_op),
    .in_gr_we(in_gr_we), .in_dest(in_dest), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we_b), .rf_waddr(rf_waddr_b), .rf_wdata(rf_wdata_b), .fwd_valid(fwd_valid_b),
    .fwd_dest(fwd_dest_b), .fwd_data_ok(fwd_data_ok_b), .debug_wb_pc(dbg_pc_b),
    .debug_wb_rf_we(dbg_we_b), .debug_wb_rf_wnum(dbg_wnum_b), .debug_wb_rf_wdata(dbg_wdata_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one held instruction slot ----------------
  bit          m_valid = 1'b0;
  bit          m_load;
  logic [2:0]  m_op;
  logic [31:0] m_alu;
  logic [31:0] m_pc;
  bit          m_we;
  logic [4:0]  m_dest;

  // Expected load result from plain shift/mask arithmetic.
  function automatic logic [31:0] m_align(input logic [2:0] op, input logic [31:0] alu,
                                          input logic [31:0] rd, input bit sub);
    int unsigned off;
    logic [31:0] v;
    off = 32'(alu[1:0]);
    if (!sub) return rd;
    case (op)
      LD_B:  begin v = (rd >> (8 * off)) & 32'hff;   if (v >= 32'd128)   v = v - 32'd256;   end
      LD_BU: v = (rd >> (8 * off)) & 32'hff;
      LD_H:  begin v = (rd >> (8 * off)) & 32'hffff; if (v >= 32'd32768) v = v - 32'd65536; end
      LD_HU: v = (rd >> (8 * off)) & 32'hffff;
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic bit m_retire();
    return m_valid && (!m_load || mem_rvalid);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
    end else if (in_valid && (!m_valid || m_retire())) begin
      m_valid <= 1'b1;
      m_load  <= in_res_from_mem;
      m_op    <= in_ld_op;
      m_alu   <= in_alu_result;
      m_pc    <= in_pc;
      m_we    <= in_gr_we;
      m_dest  <= in_dest;
    end else if (m_retire()) begin
      m_valid <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          e_ret, e_rdy, e_we, e_fv, e_ok;
  logic [31:0] e_wd_a, e_wd_b;

  always @(negedge clk) begin
    e_ok   = m_valid && (!m_load || mem_rvalid);
    e_ret  = e_ok;
    e_rdy  = !m_valid || e_ret;
    e_we   = e_ret && m_we;
    e_fv   = m_valid && m_we && (m_dest != 5'd0);
    e_wd_a = m_load ? m_align(m_op, m_alu, mem_rdata, 1'b1) : m_alu;
    e_wd_b = m_load ? m_align(m_op, m_alu, mem_rdata, 1'b0) : m_alu;
    chk("in_ready_a",    32'(in_ready_a),    32'(e_rdy));
    chk("in_ready_b",    32'(in_ready_b),    32'(e_rdy));
    chk("rf_we_a",       32'(rf_we_a),       32'(e_we));
    chk("rf_we_b",       32'(rf_we_b),       32'(e_we));
    chk("dbg_rf_we",     32'(dbg_we_a),      e_we ? 32'hf : 32'h0);
    chk("fwd_valid",     32'(fwd_valid_a),   32'(e_fv));
    chk("fwd_data_ok",   32'(fwd_data_ok_a), 32'(e_ok));
    if (e_fv) chk("fwd_dest", 32'(fwd_dest_a), 32'(m_dest));
    if (e_we) begin
      chk("rf_waddr",    32'(rf_waddr_a),    32'(m_dest));
      chk("rf_wdata_a",  rf_wdata_a,         e_wd_a);
      chk("rf_wdata_b",  rf_wdata_b,         e_wd_b);
      chk("dbg_pc",      dbg_pc_a,           m_pc);
      chk("dbg_wnum",    32'(dbg_wnum_a),    32'(m_dest));
      chk("dbg_wdata",   dbg_wdata_a,        e_wd_a);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] alu, input bit ld,
                       input logic [2:0] op, input bit we, input logic [4:0] dest,
                       input bit rv, input logic [31:0] rd);
    in_valid        = v;
    in_pc           = pc;
    in_alu_result   = alu;
    in_res_from_mem = ld;
    in_ld_op        = op;
    in_gr_we        = we;
    in_dest         = dest;
    mem_rvalid      = rv;
    mem_rdata       = rd;
  endtask

  logic [2:0]  r_op;
  logic [31:0] r_alu;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, LD_W, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_in_ready",    32'(in_ready_a),    32'd1);
    chk("rst_rf_we",       32'(rf_we_a),       32'd0);
    chk("rst_fwd_valid",   32'(fwd_valid_a),   32'd0);
    chk("rst_fwd_data_ok", 32'(fwd_data_ok_a), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back ALU ops
    drive(1, 32'h1c000000, 32'h11, 0, LD_W, 1, 5'd1, 0, 0);
    tick();
    drive(1, 32'h1c000004, 32'h22, 0, LD_W, 1, 5'd2, 0, 0);
    @(negedge clk);
    chk("b2b_pc0", dbg_pc_a, 32'h1c000000);
    chk("b2b_we0", 32'(rf_we_a), 32'd1);
    chk("b2b_rdy0", 32'(in_ready_a), 32'd1);
    tick();
    drive(1, 32'h1c000008, 32'h33, 0, LD_W, 1, 5'd3, 0, 0);
    @(negedge clk);
    chk("b2b_pc1", dbg_pc_a, 32'h1c000004);
    chk("b2b_rdy1", 32'(in_ready_a), 32'd1);
    tick();
    drive(0, 0, 0, 0, LD_W, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_pc2", dbg_pc_a, 32'h1c000008);
    chk("b2b_wd2", rf_wdata_a, 32'h33);
    tick();

    // LD_B offset 3, response 3 cycles late
    drive(1, 32'h1c000100, 32'h10000003, 1, LD_B, 1, 5'd5, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, LD_W, 0, 0, 0, 32'h80FF0000);
      @(negedge clk);
      chk("ldb_wait_rdy", 32'(in_ready_a), 32'd0);
      chk("ldb_wait_ok",  32'(fwd_data_ok_a), 32'd0);
      tick();
    end
    mem_rvalid = 1'b1;
    @(negedge clk);
    chk("ldb_we",   32'(rf_we_a), 32'd1);
    chk("ldb_data", rf_wdata_a, 32'hFFFFFF80);
    chk("ldb_raw",  rf_wdata_b, 32'h80FF0000);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("ldb_we_once", 32'(rf_we_a), 32'd0);
    tick();

    // LD_HU / LD_H offset 2
    drive(1, 32'h1c000200, 32'h20000002, 1, LD_HU, 1, 5'd6, 0, 0);
    tick();
    drive(0, 0, 0, 0, LD_W, 0, 0, 1, 32'hBEEF1234);
    @(negedge clk);
    chk("ldhu_data", rf_wdata_a, 32'h0000BEEF);
    tick();
    drive(1, 32'h1c000204, 32'h20000002, 1, LD_H, 1, 5'd6, 0, 0);
    tick();
    drive(0, 0, 0, 0, LD_W, 0, 0, 1, 32'hBEEF1234);
    @(negedge clk);
    chk("ldh_data", rf_wdata_a, 32'hFFFFBEEF);
    tick();

    // Load retiring in first WAIT cycle while the next ALU op is accepted
    drive(1, 32'h1c000300, 32'h30000000, 1, LD_W, 1, 5'd8, 0, 0);
    tick();
    drive(1, 32'h1c000304, 32'h5555, 0, LD_W, 1, 5'd9, 1, 32'hCAFEF00D);
    @(negedge clk);
    chk("ovl_rdy",  32'(in_ready_a), 32'd1);
    chk("ovl_ld",   rf_wdata_a, 32'hCAFEF00D);
    tick();
    drive(0, 0, 0, 0, LD_W, 0, 0, 0, 0);
    @(negedge clk);
    chk("ovl_alu_we", 32'(rf_we_a), 32'd1);
    chk("ovl_alu",    rf_wdata_a, 32'h5555);
    tick();

    // Reset while in WAIT; late response must be ignored
    drive(1, 32'h1c000400, 32'h40000000, 1, LD_W, 1, 5'd10, 0, 0);
    tick();
    drive(0, 0, 0, 0, LD_W, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77777777;
    @(negedge clk);
    chk("rstw_we",  32'(rf_we_a), 32'd0);
    chk("rstw_fv",  32'(fwd_valid_a), 32'd0);
    chk("rstw_rdy", 32'(in_ready_a), 32'd1);
    tick();

    // SUBWORD=0 raw word, no GPR write
    drive(1, 32'h1c000500, 32'h50000000, 1, LD_B, 0, 5'd11, 0, 0);
    tick();
    drive(0, 0, 0, 0, LD_W, 0, 0, 1, 32'h12345678);
    @(negedge clk);
    chk("sw0_raw",  rf_wdata_b, 32'h12345678);
    chk("sw1_byte", rf_wdata_a, 32'h00000078);
    chk("sw0_we",   32'(rf_we_b), 32'd0);
    tick();
    mem_rvalid = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r_op  = 3'($urandom_range(0, 4));
      r_alu = $urandom;
      if (r_op == LD_W) r_alu[1:0] = 2'b00;
      if (r_op == LD_H || r_op == LD_HU) r_alu[0] = 1'b0;
      drive($urandom_range(0, 9) < 6, $urandom, r_alu, $urandom_range(0, 1) == 1, r_op,
            $urandom_range(0, 3) != 0, 5'($urandom), $urandom_range(0, 9) < 4, $urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, LD_W, 0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
